fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the dual-clock FIFO. It is the reader counterpart to the write-side memory/pointer logic and runs entirely in the rclk domain. It synchronizes the write Gray pointer and maintains the binary and Gray read pointers. It generates empty, almost-empty and fill level, and presents data through a first-word-fall-through (FWFT) output register with a valid/ready handshake.

Parameters:
WIDTH, 4, pointer width including wrap bit; memory address is WIDTH-1 bits
DATA_WIDTH, 8, data word width
MEM_DEPTH, 2**(WIDTH-1), FIFO memory depth in words
AEMPTY_THRESH, 2, raempty asserts when rlevel <= this value

Ports:
rclk  input  1  read-domain clock (the block's single clock)
rrst_n  input  1  asynchronous active-low reset
wptr_gray  input  WIDTH  write Gray pointer from wclk domain (asynchronous; synchronized internally)
mem_rdata  input  DATA_WIDTH  combinational memory read data at raddr
raddr  output  WIDTH-1  memory read address (rbin[WIDTH-2:0])
rptr_gray  output  WIDTH  registered read Gray pointer to write domain
rempty  output  1  memory holds no unread words
raempty  output  1  almost-empty flag
rlevel  output  WIDTH  words in memory not yet loaded into the output register, 0..MEM_DEPTH
dout_valid  output  1  dout holds a valid word
dout_ready  input  1  consumer accepts dout this cycle
dout  output  DATA_WIDTH  output data register

Behaviour:
- Reset (rrst_n=0, async assert, sync-released by system): rbin=0, rptr_gray=0, sync stages=0, rempty=1, raempty=1, rlevel=0, dout_valid=0, dout=0.
- Synchronizer: wptr_gray passes through 2 rclk flops to give wq2_gray. wq2_bin = gray-to-binary(wq2_gray).
- Pop condition: rinc = !rempty && (!dout_valid || dout_ready).
- On rinc: dout <= mem_rdata (read at current raddr), dout_valid <= 1, rbin <= rbin+1 mod 2**WIDTH, rptr_gray <= bin2gray(rbin+1).
- No rinc, dout_valid && dout_ready: dout_valid <= 0; dout holds its last value.
- No rinc, !dout_ready: dout and dout_valid hold (backpressure; dout stable while valid).
- Flags are registered from next-state values:
  - rgray_next = bin2gray(rbin_next)
  - rempty <= (rgray_next == wq2_gray)
  - rlevel <= wq2_bin - rbin_next (modulo 2**WIDTH, WIDTH bits)
  - raempty <= (rlevel_next <= AEMPTY_THRESH)
- Latency: a wptr_gray change first sampled at rclk edge k gives wq2 at k+1, rempty=0 at k+2, dout_valid=1 at k+3 (if the output register is free).
- Throughput: with dout_ready=1 held and data available, one word per rclk. Simultaneous consume and reload keeps dout_valid=1 with no bubble.
- Drain: when the last word loads, rempty=1 at the same edge. dout_valid drops on the following accepted handshake.
- Wrap-around: the MSB of rbin toggles every MEM_DEPTH reads. Gray pointer returns to 0 after 2*MEM_DEPTH reads. Empty compares full WIDTH bits, so a full FIFO (level MEM_DEPTH) is never mistaken for empty.
- Pessimism: rempty and rlevel may lag actual writes by up to 3 rclk. They are never optimistic.
- Reset mid-operation: every register clears immediately, including a pending dout (discarded). The write side must be reset in the same system reset event.
- wptr_gray glitches or inputs that are not valid Gray codes are outside the contract.

Decomposition:
- Package fifo_pkg:
  - WIDTH/DATA_WIDTH defaults
  - functions bin2gray and gray2bin, parameterized by WIDTH
  - ptr_t typedef (logic [WIDTH-1:0])
- Sub-module sync_w2r: 2-flop synchronizer, WIDTH bits, rclk/rrst_n, reset to 0. The write side reuses it as sync_r2w.

Test Plan:
- Reset: assert rrst_n=0 mid-cycle -> immediately rempty=1, raempty=1, rlevel=0, dout_valid=0, raddr=0, rptr_gray=4'b0000.
- Single word: wptr_gray 0000->0001 at edge k, mem_rdata=8'hA5, dout_ready=0 -> rempty=0 at k+2; dout=8'hA5, dout_valid=1, raddr=1, rptr_gray=0001 at k+3; dout holds while ready=0.
- Fill to full: wptr_gray=4'b1100 (bin 8), no reads -> rlevel=8, rempty=0, raempty=0 after 3 cycles. After the first auto-load, rlevel=7.
- Streaming drain: FIFO holds 8 words 8'h00..8'h07, dout_ready=1 -> dout sequence 00..07 on consecutive cycles. rempty=1 once the 8th word loads; raempty asserts when rlevel<=2; dout_valid=0 after 07 is accepted.
- Wrap-around: 16 write/read cycles with 16 words streamed -> rptr_gray returns to 4'b0000, raddr returns to 0, rempty correct at every step, no duplicated or dropped word.
- Reset mid-stream: rrst_n=0 while dout_valid=1 and rlevel=5 -> all outputs at reset values. After release with wptr_gray=0, the block stays empty.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer type and Gray/binary helpers for the dual-clock FIFO.
// Both clock domains import this so their pointer encodings always agree.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH      = 4;
    localparam int unsigned FIFO_DATA_WIDTH = 8;

    typedef logic [FIFO_WIDTH-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[FIFO_WIDTH-1] = gray[FIFO_WIDTH-1];
        for (int i = int'(FIFO_WIDTH) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_w2r.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
// Also instantiated on the write side as the read-pointer synchronizer.
module sync_w2r #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: pointer sync, read pointers, empty/level
// flags and a first-word-fall-through output register with valid/ready handshake.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH         = FIFO_WIDTH,
    parameter int unsigned DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH     = 2 ** (WIDTH - 1),
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                         rclk,
    input  logic                         rrst_n,
    input  logic [WIDTH-1:0]             wptr_gray,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic [$clog2(MEM_DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]             rptr_gray,
    output logic                         rempty,
    output logic                         raempty,
    output logic [WIDTH-1:0]             rlevel,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [DATA_WIDTH-1:0]        dout
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam logic [WIDTH-1:0] AE_THRESH = WIDTH'(AEMPTY_THRESH);

    logic [WIDTH-1:0]      wq2_gray;
    logic [WIDTH-1:0]      wq2_bin;
    logic                  rinc;
    logic [WIDTH-1:0]      rbin_q, rbin_d;
    logic [WIDTH-1:0]      rgray_q, rgray_d;
    logic [WIDTH-1:0]      rlevel_q, rlevel_d;
    logic                  rempty_q, rempty_d;
    logic                  raempty_q, raempty_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    sync_w2r #(
        .WIDTH (WIDTH)
    ) u_sync_w2r (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .d_i    (wptr_gray),
        .q_o    (wq2_gray)
    );

    assign wq2_bin = gray2bin(wq2_gray);

    always_comb begin
        rinc         = !rempty_q && (!dout_valid_q || dout_ready);
        rbin_d       = rinc ? rbin_q + WIDTH'(1) : rbin_q;
        rgray_d      = bin2gray(rbin_d);
        // Full-width compare: a full FIFO differs from the read pointer in the wrap bit.
        rempty_d     = (rgray_d == wq2_gray);
        rlevel_d     = wq2_bin - rbin_d;
        raempty_d    = (rlevel_d <= AE_THRESH);
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (rinc) begin
            dout_d       = mem_rdata;
            dout_valid_d = 1'b1;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rgray_q      <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            rbin_q       <= rbin_d;
            rgray_q      <= rgray_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
        end
    end

    assign raddr      = rbin_q[AW-1:0];
    assign rptr_gray  = rgray_q;
    assign rempty     = rempty_q;
    assign raempty    = raempty_q;
    assign rlevel     = rlevel_q;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;

endmodule
